// File: rtl/cu_mod0_1.sv
// cu_mod0_1: control unit for FFT stage 0_1.
// Tracks the sample index within a BLK-sample frame, raises the butterfly
// enable for the upper half of every 2*DLY group, and replays DLY flush
// cycles after the last sample so each frame yields exactly BLK output valids.
// Optional feature: define CU_MOD0_1_ERR_EN to build the protocol-error
// detector driving err_proto; otherwise err_proto is tied low.
module cu_mod0_1 #(
  parameter int unsigned DLY = 8,
  parameter int unsigned BLK = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic alert_mod01,
  input  logic valid_fac8_0,
  output logic bf_en,
  output logic valid_fac8_1,
  output logic alert_mod02,
  output logic err_proto
);

  localparam int unsigned CntW   = $clog2(BLK);
  localparam int unsigned FcW    = $clog2(DLY);
  localparam int unsigned DlyBit = $clog2(DLY);

  localparam logic [CntW-1:0] CntLast = CntW'(BLK - 1);
  localparam logic [CntW-1:0] CntDly  = CntW'(DLY);
  localparam logic [FcW-1:0]  FcLast  = FcW'(DLY - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [FcW-1:0]  r_fcnt, w_fcnt_nxt;
  logic            r_bf_en, r_vld, r_alert2;

  logic            w_accept;
  logic [CntW-1:0] w_idx;
  logic            w_bf_nxt, w_vld_nxt, w_alert2_nxt;

  // A new frame may start from any state; its first sample is index 0.
  assign w_accept = valid_fac8_0 && ((r_state == StRun) || alert_mod01);
  assign w_idx    = alert_mod01 ? '0 : r_cnt;

  // Next-state logic: frame start overrides everything, abandoning any flush.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fcnt_nxt  = r_fcnt;
    if (alert_mod01) begin
      w_state_nxt = StRun;
      w_cnt_nxt   = w_accept ? CntW'(1) : '0;
      w_fcnt_nxt  = '0;
    end else begin
      case (r_state)
        StRun: begin
          if (w_accept) begin
            // Index wraps to 0 after the last sample since BLK is a power of two.
            w_cnt_nxt = r_cnt + CntW'(1);
            if (r_cnt == CntLast) begin
              w_state_nxt = StFlush;
              w_fcnt_nxt  = '0;
            end
          end
        end
        StFlush: begin
          if (r_fcnt == FcLast) begin
            w_state_nxt = StIdle;
            w_fcnt_nxt  = '0;
          end else begin
            w_fcnt_nxt = r_fcnt + FcW'(1);
          end
        end
        StIdle: begin
          w_state_nxt = StIdle;
        end
        default: begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
          w_fcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Output decode for the registered outputs; flush valids stop on a new frame.
  always_comb begin
    w_bf_nxt     = w_accept && w_idx[DlyBit];
    w_vld_nxt    = w_accept ? (w_idx >= CntDly) : ((r_state == StFlush) && !alert_mod01);
    w_alert2_nxt = w_accept && (w_idx == CntDly);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_fcnt   <= '0;
      r_bf_en  <= 1'b0;
      r_vld    <= 1'b0;
      r_alert2 <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_bf_en  <= w_bf_nxt;
      r_vld    <= w_vld_nxt;
      r_alert2 <= w_alert2_nxt;
    end
  end

  assign bf_en        = r_bf_en;
  assign valid_fac8_1 = r_vld;
  assign alert_mod02  = r_alert2;

`ifdef CU_MOD0_1_ERR_EN
  logic r_err, w_err_nxt;

  // Error: frame start while busy, or a sample arriving outside RUN without a frame start.
  always_comb begin
    w_err_nxt = (alert_mod01 && (r_state != StIdle)) ||
                (valid_fac8_0 && !alert_mod01 && (r_state != StRun));
  end

  // Registered error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
    end
  end

  assign err_proto = r_err;
`else
  assign err_proto = 1'b0;
`endif

endmodule

// File: tb/tb_cu_mod0_1.sv
// Self-checking bench for cu_mod0_1 (DLY=8, BLK=64).
// Expected outputs are derived from the frame-index rules and pushed to a
// scoreboard queue as each cycle's stimulus is driven, then popped and
// compared one time unit after the clock edge that registers them.
module tb_cu_mod0_1;

  localparam int DLY = 8;
  localparam int BLK = 64;
`ifdef CU_MOD0_1_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic alert_mod01 = 1'b0;
  logic valid_fac8_0 = 1'b0;
  logic bf_en, valid_fac8_1, alert_mod02, err_proto;

  typedef struct packed {
    logic bf;
    logic vld;
    logic a2;
    logic err;
  } out_t;

  typedef struct {
    logic alert;
    logic valid;
    out_t exp;
  } vec_t;

  out_t sb_q[$];
  vec_t tbl[17];
  int   n_tests = 0;
  int   n_fail = 0;
  int   vld_cnt = 0;
  int   a2_cnt = 0;

  cu_mod0_1 #(
    .DLY(DLY),
    .BLK(BLK)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .alert_mod01 (alert_mod01),
    .valid_fac8_0(valid_fac8_0),
    .bf_en       (bf_en),
    .valid_fac8_1(valid_fac8_1),
    .alert_mod02 (alert_mod02),
    .err_proto   (err_proto)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(logic bf, logic vld, logic a2, logic err);
    out_t o;
    o.bf  = bf;
    o.vld = vld;
    o.a2  = a2;
    o.err = err & ErrEn;
    return o;
  endfunction

  // Output following the accept of in-frame sample idx.
  function automatic out_t acc(int idx);
    return mk(((idx / DLY) % 2) == 1, idx >= DLY, idx == DLY, 1'b0);
  endfunction

  task automatic check(string name, int t);
    out_t got;
    out_t e;
    got = {bf_en, valid_fac8_1, alert_mod02, err_proto};
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s t=%0d: scoreboard empty, got bf/vld/a2/err=%b", name, t, got);
      return;
    end
    e = sb_q.pop_front();
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s t=%0d: got bf/vld/a2/err=%b required %b", name, t, got, e);
    end
    if (got.vld === 1'b1) vld_cnt++;
    if (got.a2 === 1'b1) a2_cnt++;
  endtask

  task automatic step(string name, int t, logic a, logic v, out_t e);
    alert_mod01  = a;
    valid_fac8_0 = v;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check(name, t);
  endtask

  task automatic check_cnt(string name, int got, int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  initial begin
    // Table: idle errors, frame start without sample, valid gap, re-alert in RUN.
    tbl[0] = '{1'b0, 1'b1, mk(0, 0, 0, 1)};
    tbl[1] = '{1'b0, 1'b0, mk(0, 0, 0, 0)};
    tbl[2] = '{1'b0, 1'b1, mk(0, 0, 0, 1)};
    tbl[3] = '{1'b1, 1'b0, mk(0, 0, 0, 0)};
    for (int i = 0; i < 8; i++) tbl[4 + i] = '{1'b0, 1'b1, acc(i)};
    tbl[12] = '{1'b0, 1'b1, acc(8)};
    tbl[13] = '{1'b0, 1'b0, mk(0, 0, 0, 0)};
    tbl[14] = '{1'b0, 1'b1, acc(9)};
    tbl[15] = '{1'b1, 1'b0, mk(0, 0, 0, 1)};
    tbl[16] = '{1'b1, 1'b1, mk(0, 0, 0, 1)};

    // Scenario 1: reset values, then idle cycles.
    #2;
    sb_q.push_back(mk(0, 0, 0, 0));
    check("reset", 0);
    #6;
    rstn = 1'b1;
    for (int t = 0; t < 10; t++) step("idle", t, 1'b0, 1'b0, mk(0, 0, 0, 0));

    // Scenario 2: contiguous frame.
    vld_cnt = 0;
    a2_cnt  = 0;
    for (int t = 0; t < 76; t++) begin
      out_t e;
      if (t < BLK) e = acc(t);
      else if (t < BLK + DLY) e = mk(0, 1, 0, 0);
      else e = mk(0, 0, 0, 0);
      step("frame", t, t == 0, t < BLK, e);
    end
    check_cnt("frame_vld_total", vld_cnt, BLK);
    check_cnt("frame_a2_total", a2_cnt, 1);

    // Scenario 3: valid every other cycle.
    vld_cnt = 0;
    a2_cnt  = 0;
    for (int t = 0; t < 138; t++) begin
      out_t e;
      logic v;
      v = (t % 2 == 0) && (t < 2 * BLK);
      if (v) e = acc(t / 2);
      else if (t >= 2 * BLK - 1 && t < 2 * BLK - 1 + DLY) e = mk(0, 1, 0, 0);
      else e = mk(0, 0, 0, 0);
      step("gapped", t, t == 0, v, e);
    end
    check_cnt("gapped_vld_total", vld_cnt, BLK);
    check_cnt("gapped_a2_total", a2_cnt, 1);

    // Scenario 4 and misc corner cases from the table; ends in RUN with cnt=1.
    for (int i = 0; i < 17; i++) step("table", i, tbl[i].alert, tbl[i].valid, tbl[i].exp);

    // Scenario 5: continue to sample 19, re-alert with valid at sample 20.
    for (int i = 1; i < 20; i++) step("pre_realert", i, 1'b0, 1'b1, acc(i));
    step("realert", 20, 1'b1, 1'b1, mk(0, 0, 0, 1));
    for (int i = 1; i < 30; i++) step("post_realert", i, 1'b0, 1'b1, acc(i));

    // Scenario 6: asynchronous reset while sample 30 is presented.
    valid_fac8_0 = 1'b1;
    #1;
    rstn = 1'b0;
    #1;
    sb_q.push_back(mk(0, 0, 0, 0));
    check("async_reset", 30);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int t = 0; t < 10; t++) step("post_reset", t, 1'b0, 1'b1, mk(0, 0, 0, 1));
    step("post_reset_quiet", 10, 1'b0, 1'b0, mk(0, 0, 0, 0));

    // Flush corner cases: stray valid in FLUSH, then new frame dropping the flush.
    for (int t = 0; t < BLK; t++) step("flushcase", t, t == 0, 1'b1, acc(t));
    step("flush_idle", 64, 1'b0, 1'b0, mk(0, 1, 0, 0));
    step("flush_stray", 65, 1'b0, 1'b1, mk(0, 1, 0, 1));
    step("flush_idle", 66, 1'b0, 1'b0, mk(0, 1, 0, 0));
    step("flush_alert", 67, 1'b1, 1'b0, mk(0, 0, 0, 1));
    step("flush_dropped", 68, 1'b0, 1'b0, mk(0, 0, 0, 0));
    step("flush_dropped", 69, 1'b0, 1'b0, mk(0, 0, 0, 0));
    for (int i = 0; i < 10; i++) step("newframe", i, 1'b0, 1'b1, acc(i));

    check_cnt("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
